scaler_read_arbiter: RTL and testbench
======================================

SCALER_READ_ARBITER -- requirements
Module: scaler_read_arbiter

Interface
REQ-001 Parameter SETTLE, default 4: cycles the read strobes are held low before the first sample; legal range 1..15.
REQ-002 Parameter MAXTRY, default 3: maximum resample attempts after a mismatch; legal range 0..7.
REQ-003 SIM_CLK  in  1  single clock; all state changes on its rising edge.
REQ-004 SIM_RST  in  1  synchronous active-high reset.
REQ-005 REQ0, REQ1  in  1 each  read requests; the requester holds REQ high until it sees its ACK.
REQ-006 CHAT01..CHAT14  in  1 each  scaler high-half bits (channel 3), valid while RCHAT_ is low.
REQ-007 CHBT01..CHBT14  in  1 each  scaler low-half bits (channel 4), valid while RCHBT_ is low.
REQ-008 RCHAT_, RCHBT_  out  1 each  active-low scaler read strobes, always driven identically.
REQ-009 ACK0, ACK1  out  1 each  one-cycle completion pulse to the granted requester.
REQ-010 RDATA  out  28  captured value; RDATA[27:14]=CHAT14..CHAT01, RDATA[13:0]=CHBT14..CHBT01.
REQ-011 ERR  out  1  high when the delivered value failed the stability check.
REQ-012 BUSY  out  1  high in every state except IDLE.

Function
REQ-013 FSM states: IDLE, WAIT, SAMP1, SAMP2, DONE.
REQ-014 IDLE: if any REQ is high at edge k, latch the grant, go to WAIT, and drive strobes low from edge k.
REQ-015 Arbitration is round-robin. A lone request is granted directly. On simultaneous requests, the requester not granted last wins. After reset, REQ0 wins the first tie.
REQ-016 WAIT: a settle counter runs for SETTLE cycles; at edge k+SETTLE the FSM goes to SAMP1.
REQ-017 SAMP1: at the next edge, register the 28 live input bits into sample A and go to SAMP2.
REQ-018 SAMP2 match: compare A with the live inputs. If equal, load RDATA from the live inputs, set ERR=0 and go to DONE.
REQ-019 SAMP2 mismatch: if retries < MAXTRY, reload A from the live inputs, increment retries and stay in SAMP2, adding one cycle per retry.
REQ-020 SAMP2 mismatch with retries = MAXTRY: load RDATA from the live inputs, set ERR=1 and go to DONE.
REQ-021 On entry to DONE, strobes go high and the granted ACK is high for exactly one cycle; the FSM then returns to IDLE with ACK low.
REQ-022 No-retry latency: ACK rises at edge k+SETTLE+2 (edge k+6 at the default SETTLE). Each retry adds one cycle.
REQ-023 RDATA and ERR hold their values until the next DONE entry.
REQ-024 A REQ that drops mid-read does not abort the read; the granted ACK still pulses.
REQ-025 The non-granted REQ is ignored until IDLE. A REQ held high through DONE is re-evaluated in IDLE, which yields a back-to-back grant one cycle after ACK.
REQ-026 The retry counter and settle counter clear on every IDLE to WAIT transition.

Reset
REQ-027 While SIM_RST is high at an edge, the block enters IDLE, regardless of current state.
REQ-028 Reset values: RCHAT_=RCHBT_=1, ACK0=ACK1=0, BUSY=0, ERR=0, RDATA=0, counters=0, round-robin pointer favouring REQ0.
REQ-029 Reset during WAIT, SAMP1 or SAMP2 produces no ACK, and strobes are high after that edge.

Configuration
REQ-030 Macro SCALER_ARB_STABLE_EN defined: the double-sample check of REQ-018..REQ-020 is compiled in.
REQ-031 Macro SCALER_ARB_STABLE_EN undefined: SAMP2 is removed, and SAMP1 loads RDATA directly and goes to DONE. ERR is tied 0, MAXTRY is ignored, and ACK rises at edge k+SETTLE+1.

Verification
REQ-032 Single request, macro defined: REQ0 at edge 0, CHAT=14'o12345, CHBT=14'o00017 held constant, SETTLE=4 -> strobes low 6 cycles, ACK0 at edge 6, RDATA={14'o12345,14'o00017}, ERR=0, BUSY high edges 0..6.
REQ-033 Tie after reset: REQ0 and REQ1 high together -> ACK0 at edge 6, ACK1 at edge 13. A second simultaneous pair -> REQ0 served before REQ1 again, because REQ1 was granted last.
REQ-034 One glitch: CHBT changes 14'o00017 to 14'o00020 between SAMP1 and SAMP2, then holds -> one retry, ACK at edge 7, RDATA low half 14'o00020, ERR=0.
REQ-035 Unstable input: CHBT01 toggles every cycle, MAXTRY=3 -> ACK at edge 9, ERR=1, and ERR stays 1 until the next successful read clears it.
REQ-036 Reset mid-read: SIM_RST high at edge 3 of a REQ1 read -> strobes high and BUSY=0 from edge 3, no ACK1 pulse, next REQ0 served normally.
REQ-037 Macro undefined: REQ-032 stimulus -> ACK0 at edge 5, same RDATA, ERR=0. Toggling CHBT01 -> ERR stays 0.

Source files
------------

// File: rtl/scaler_read_arbiter.sv
// scaler_read_arbiter: two-requester round-robin arbiter for the 28-bit
// scaler read. It lowers the read strobes, waits SETTLE cycles, samples the
// scaler and pulses ACK to the granted requester.
// Optional feature macro: SCALER_ARB_STABLE_EN. When it is defined, the
// sample is taken twice, and a mismatch is retried up to MAXTRY times.
module scaler_read_arbiter #(
  parameter int SETTLE = 4,   // 1..15
  parameter int MAXTRY = 3    // 0..7
) (
  input  logic        SIM_CLK,
  input  logic        SIM_RST,
  input  logic        REQ0,
  input  logic        REQ1,
  input  logic        CHAT01,
  input  logic        CHAT02,
  input  logic        CHAT03,
  input  logic        CHAT04,
  input  logic        CHAT05,
  input  logic        CHAT06,
  input  logic        CHAT07,
  input  logic        CHAT08,
  input  logic        CHAT09,
  input  logic        CHAT10,
  input  logic        CHAT11,
  input  logic        CHAT12,
  input  logic        CHAT13,
  input  logic        CHAT14,
  input  logic        CHBT01,
  input  logic        CHBT02,
  input  logic        CHBT03,
  input  logic        CHBT04,
  input  logic        CHBT05,
  input  logic        CHBT06,
  input  logic        CHBT07,
  input  logic        CHBT08,
  input  logic        CHBT09,
  input  logic        CHBT10,
  input  logic        CHBT11,
  input  logic        CHBT12,
  input  logic        CHBT13,
  input  logic        CHBT14,
  output logic        RCHAT_,
  output logic        RCHBT_,
  output logic        ACK0,
  output logic        ACK1,
  output logic [27:0] RDATA,
  output logic        ERR,
  output logic        BUSY
);

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_SAMP1,
`ifdef SCALER_ARB_STABLE_EN
    S_SAMP2,
`endif
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        grant_q, grant_d;   // index of the requester being served
  logic        last_q,  last_d;    // index of the requester granted last
  logic [3:0]  settle_q, settle_d;
  logic [27:0] rdata_q, rdata_d;
  logic [27:0] live;
  logic        req0_m, req1_m, any_req, pick;

`ifdef SCALER_ARB_STABLE_EN
  localparam logic [2:0] MAXTRY_L = 3'(MAXTRY);
  logic [27:0] samp_a_q, samp_a_d;
  logic [2:0]  retry_q, retry_d;
  logic        err_q, err_d;
`else
  logic unused_maxtry;
  assign unused_maxtry = ^3'(MAXTRY);
`endif

  assign live = {CHAT14, CHAT13, CHAT12, CHAT11, CHAT10, CHAT09, CHAT08,
                 CHAT07, CHAT06, CHAT05, CHAT04, CHAT03, CHAT02, CHAT01,
                 CHBT14, CHBT13, CHBT12, CHBT11, CHBT10, CHBT09, CHBT08,
                 CHBT07, CHBT06, CHBT05, CHBT04, CHBT03, CHBT02, CHBT01};

  // In DONE, the requester being acked is masked. Its REQ is still high for
  // that cycle, and this mask stops it from being re-served. The other
  // requester can be granted straight out of DONE.
  always_comb begin
    req0_m  = REQ0 & ~((state_q == S_DONE) & (grant_q == 1'b0));
    req1_m  = REQ1 & ~((state_q == S_DONE) & (grant_q == 1'b1));
    any_req = req0_m | req1_m;
    // On a tie, the requester not granted last wins. A lone request wins directly.
    pick    = (req0_m & req1_m) ? ~last_q : req1_m;
  end

  // Next-state logic and datapath loads
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    settle_d = settle_q;
    rdata_d  = rdata_q;
`ifdef SCALER_ARB_STABLE_EN
    samp_a_d = samp_a_q;
    retry_d  = retry_q;
    err_d    = err_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (any_req) begin
          state_d  = S_WAIT;
          grant_d  = pick;
          last_d   = pick;
          settle_d = 4'd0;
`ifdef SCALER_ARB_STABLE_EN
          retry_d  = 3'd0;
`endif
        end else begin
          state_d  = S_IDLE;
        end
      end
      S_WAIT: begin
        if (settle_q == SETTLE_M1) state_d  = S_SAMP1;
        else                       settle_d = settle_q + 4'd1;
      end
      S_SAMP1: begin
`ifdef SCALER_ARB_STABLE_EN
        samp_a_d = live;
        state_d  = S_SAMP2;
`else
        rdata_d  = live;
        state_d  = S_DONE;
`endif
      end
`ifdef SCALER_ARB_STABLE_EN
      S_SAMP2: begin
        if (samp_a_q == live) begin
          rdata_d = live;
          err_d   = 1'b0;
          state_d = S_DONE;
        end else if (retry_q < MAXTRY_L) begin
          samp_a_d = live;
          retry_d  = retry_q + 3'd1;
        end else begin
          rdata_d = live;
          err_d   = 1'b1;
          state_d = S_DONE;
        end
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers, with synchronous reset
  always_ff @(posedge SIM_CLK) begin
    if (SIM_RST) begin
      state_q  <= S_IDLE;
      grant_q  <= 1'b0;
      last_q   <= 1'b1;   // so that REQ0 wins the first tie
      settle_q <= 4'd0;
      rdata_q  <= 28'd0;
`ifdef SCALER_ARB_STABLE_EN
      samp_a_q <= 28'd0;
      retry_q  <= 3'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      settle_q <= settle_d;
      rdata_q  <= rdata_d;
`ifdef SCALER_ARB_STABLE_EN
      samp_a_q <= samp_a_d;
      retry_q  <= retry_d;
      err_q    <= err_d;
`endif
    end
  end

  // Outputs decoded from state. The strobes are low for the whole read window.
  always_comb begin
    BUSY   = (state_q != S_IDLE);
    RCHAT_ = (state_q == S_IDLE) | (state_q == S_DONE);
    RCHBT_ = (state_q == S_IDLE) | (state_q == S_DONE);
    ACK0   = (state_q == S_DONE) & (grant_q == 1'b0);
    ACK1   = (state_q == S_DONE) & (grant_q == 1'b1);
    RDATA  = rdata_q;
`ifdef SCALER_ARB_STABLE_EN
    ERR    = err_q;
`else
    ERR    = 1'b0;
`endif
  end

endmodule

// File: tb/tb_scaler_read_arbiter.sv
// Directed bench for scaler_read_arbiter (SETTLE=4, MAXTRY=3). It checks
// each step on the cycle after the clock edge.
module tb_scaler_read_arbiter;

`ifdef SCALER_ARB_STABLE_EN
  localparam int LAT = 6;
`else
  localparam int LAT = 5;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [13:0] cha = '0, chb = '0;
  logic        rchat_n, rchbt_n, ack0, ack1, err, busy;
  logic [27:0] rdata;
  int          n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  scaler_read_arbiter #(.SETTLE(4), .MAXTRY(3)) dut (
    .SIM_CLK(clk), .SIM_RST(rst), .REQ0(req0), .REQ1(req1),
    .CHAT01(cha[0]), .CHAT02(cha[1]), .CHAT03(cha[2]), .CHAT04(cha[3]),
    .CHAT05(cha[4]), .CHAT06(cha[5]), .CHAT07(cha[6]), .CHAT08(cha[7]),
    .CHAT09(cha[8]), .CHAT10(cha[9]), .CHAT11(cha[10]), .CHAT12(cha[11]),
    .CHAT13(cha[12]), .CHAT14(cha[13]),
    .CHBT01(chb[0]), .CHBT02(chb[1]), .CHBT03(chb[2]), .CHBT04(chb[3]),
    .CHBT05(chb[4]), .CHBT06(chb[5]), .CHBT07(chb[6]), .CHBT08(chb[7]),
    .CHBT09(chb[8]), .CHBT10(chb[9]), .CHBT11(chb[10]), .CHBT12(chb[11]),
    .CHBT13(chb[12]), .CHBT14(chb[13]),
    .RCHAT_(rchat_n), .RCHBT_(rchbt_n), .ACK0(ack0), .ACK1(ack1),
    .RDATA(rdata), .ERR(err), .BUSY(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    cyc(); cyc();
    rst = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset();
    chk("rst_rchat", {31'd0, rchat_n}, 32'd1);
    chk("rst_rchbt", {31'd0, rchbt_n}, 32'd1);
    chk("rst_ack",   {30'd0, ack1, ack0}, 32'd0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_rdata", {4'd0, rdata}, 32'd0);

    // Single REQ0 read with constant inputs
    cha = 14'o12345; chb = 14'o00017; req0 = 1'b1;
    cyc();                                        // edge 0
    chk("s_busy0", {31'd0, busy}, 32'd1);
    for (int e = 0; e < LAT; e++) begin
      if (e > 0) cyc();
      chk("s_strobe_low", {30'd0, rchat_n, rchbt_n}, 32'd0);
      chk("s_noack", {30'd0, ack1, ack0}, 32'd0);
    end
    cyc();                                        // edge LAT
    chk("s_ack0",  {30'd0, ack1, ack0}, 32'd1);
    chk("s_rdata", {4'd0, rdata}, {4'd0, 14'o12345, 14'o00017});
    chk("s_err",   {31'd0, err}, 32'd0);
    chk("s_strobe_hi", {30'd0, rchat_n, rchbt_n}, 32'd3);
    chk("s_busy_done", {31'd0, busy}, 32'd1);
    req0 = 1'b0;
    cyc();
    chk("s_ack_low", {30'd0, ack1, ack0}, 32'd0);
    chk("s_idle",    {31'd0, busy}, 32'd0);
    chk("s_hold",    {4'd0, rdata}, {4'd0, 14'o12345, 14'o00017});

    // Tie after reset: REQ0 first, then REQ1 back to back
    do_reset();
    req0 = 1'b1; req1 = 1'b1;
    cyc();                                        // edge 0
    for (int e = 1; e < LAT; e++) cyc();
    cyc();                                        // edge LAT
    chk("t1_ack0", {30'd0, ack1, ack0}, 32'd1);
    req0 = 1'b0;
    cyc();                                        // edge LAT+1: REQ1 granted
    chk("t1_busy_b2b", {31'd0, busy}, 32'd1);
    chk("t1_strobe_b2b", {31'd0, rchat_n}, 32'd0);
    for (int e = 1; e < LAT; e++) begin
      cyc();
      chk("t1_wait1", {30'd0, ack1, ack0}, 32'd0);
    end
    cyc();                                        // edge 2*LAT+1
    chk("t1_ack1", {30'd0, ack1, ack0}, 32'd2);
    req1 = 1'b0;
    cyc();
    chk("t1_idle", {31'd0, busy}, 32'd0);
    // Second pair: REQ1 was granted last, so REQ0 is served first again
    req0 = 1'b1; req1 = 1'b1;
    cyc();
    for (int e = 1; e <= LAT; e++) cyc();
    chk("t2_ack0", {30'd0, ack1, ack0}, 32'd1);
    req0 = 1'b0;
    for (int e = 0; e <= LAT; e++) cyc();
    chk("t2_ack1", {30'd0, ack1, ack0}, 32'd2);
    req1 = 1'b0;
    cyc();

    // One glitch between SAMP1 and SAMP2
    cha = 14'o12345; chb = 14'o00017; req0 = 1'b1;
    cyc();                                        // edge 0
    for (int e = 1; e <= 5; e++) cyc();           // edge 5: SAMP1 samples
`ifdef SCALER_ARB_STABLE_EN
    chb = 14'o00020;
    cyc();                                        // edge 6: mismatch, retry
    chk("g_noack6", {30'd0, ack1, ack0}, 32'd0);
    cyc();                                        // edge 7
    chk("g_ack7",  {30'd0, ack1, ack0}, 32'd1);
    chk("g_rdata", {4'd0, rdata}, {4'd0, 14'o12345, 14'o00020});
    chk("g_err",   {31'd0, err}, 32'd0);
`else
    chk("g_ack5",  {30'd0, ack1, ack0}, 32'd1);
    chk("g_rdata", {4'd0, rdata}, {4'd0, 14'o12345, 14'o00017});
    chk("g_err",   {31'd0, err}, 32'd0);
`endif
    req0 = 1'b0;
    cyc();

    // Unstable input: CHBT01 toggles every cycle
    chb = 14'o00016; req1 = 1'b1;
    cyc();                                        // edge 0 (CHBT01=0)
    chb[0] = ~chb[0];
    for (int e = 1; e < LAT; e++) begin cyc(); chb[0] = ~chb[0]; end
`ifdef SCALER_ARB_STABLE_EN
    for (int e = LAT; e < 9; e++) begin
      cyc();
      chk("u_retry_noack", {30'd0, ack1, ack0}, 32'd0);
      chb[0] = ~chb[0];
    end
    cyc();                                        // edge 9 (CHBT01=1)
    chk("u_ack9",  {30'd0, ack1, ack0}, 32'd2);
    chk("u_err",   {31'd0, err}, 32'd1);
    chk("u_rdata", {4'd0, rdata}, {4'd0, 14'o12345, 14'o00017});
    req1 = 1'b0; chb = 14'o00016;
    cyc();
    chk("u_err_hold", {31'd0, err}, 32'd1);
    // A clean read clears ERR, but only at its DONE
    req0 = 1'b1;
    cyc();
    for (int e = 1; e < LAT; e++) cyc();
    chk("u_err_until_done", {31'd0, err}, 32'd1);
    cyc();
    chk("u_clean_ack", {30'd0, ack1, ack0}, 32'd1);
    chk("u_err_clr",   {31'd0, err}, 32'd0);
    chk("u_clean_rd",  {4'd0, rdata}, {4'd0, 14'o12345, 14'o00016});
    req0 = 1'b0;
    cyc();
`else
    cyc();                                        // edge 5 (CHBT01=1)
    chk("u_ack5",  {30'd0, ack1, ack0}, 32'd2);
    chk("u_err0",  {31'd0, err}, 32'd0);
    chk("u_rdata", {4'd0, rdata}, {4'd0, 14'o12345, 14'o00017});
    req1 = 1'b0; chb = 14'o00016;
    cyc();
    chk("u_err_stays0", {31'd0, err}, 32'd0);
`endif

    // Reset in the middle of a REQ1 read
    req1 = 1'b1;
    cyc();                                        // edge 0
    cyc(); cyc();                                 // edge 2
    chk("r_strobe_mid", {31'd0, rchat_n}, 32'd0);
    rst = 1'b1;
    cyc();                                        // edge 3: reset sampled
    chk("r_strobe_hi", {30'd0, rchat_n, rchbt_n}, 32'd3);
    chk("r_busy0", {31'd0, busy}, 32'd0);
    rst = 1'b0; req1 = 1'b0;
    for (int e = 0; e < 8; e++) begin
      cyc();
      chk("r_no_ack1", {31'd0, ack1}, 32'd0);
    end
    cha = 14'o00777; chb = 14'o07000; req0 = 1'b1;
    cyc();
    for (int e = 1; e <= LAT; e++) cyc();
    chk("r_next_ack0", {30'd0, ack1, ack0}, 32'd1);
    chk("r_next_rdata", {4'd0, rdata}, {4'd0, 14'o00777, 14'o07000});
    req0 = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
